uart_tx_arbiter: RTL and testbench

Shares one serial TX line between NUM_REQ bus-side requesters and sequences each granted word onto it as DATA_WIDTH/8 UART bytes. Bytes are sent low byte first and each byte is LSB first, in 8N1 framing with 16 clken ticks per bit. This matches the framing and byte order the link's 32-bit UART receiver reassembles. The block sits between the bus bridge's outbound requesters and the UART pin and provides round-robin arbitration, word latching and bit timing.

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART transmitter: requests, words in,
// grant/status and the serial line out.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          done;
  logic                          tx;

  modport master (
    output req, data_in,
    input  grant, busy, done, tx
  );

  modport slave (
    input  req, data_in,
    output grant, busy, done, tx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that latches one requester's word and serialises it as
// DATA_WIDTH/8 low-byte-first 8N1 UART frames at 16 clken ticks per bit.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clken,
  uart_tx_arbiter_if.slave  bus
);

  localparam int              NB         = DATA_WIDTH / 8;
  localparam int              IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [1:0]      LAST_BYTE  = 2'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             sample_q, sample_d;
  logic [2:0]             bit_pos_q, bit_pos_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_q, tx_d;

  logic                   any_req;
  logic [IDX_W-1:0]       winner;
  logic                   tick_end;
  logic [7:0]             cur_byte;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % NUM_REQ);
  endfunction

  // Scan from the farthest candidate back to last+1 so the nearest requester
  // after the previous winner is the one left standing.
  always_comb begin
    any_req = 1'b0;
    winner  = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[rr_index(last_q, k)]) begin
        any_req = 1'b1;
        winner  = rr_index(last_q, k);
      end
    end
  end

  assign tick_end = clken && (sample_q == 4'd15);
  assign cur_byte = word_q[8*byte_idx_q +: 8];

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    bit_pos_d  = bit_pos_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    last_d     = last_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    grant_d    = '0;
    done_d     = 1'b0;

    if (state_q != IDLE && clken) begin
      sample_d = sample_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          word_d     = bus.data_in[winner*DATA_WIDTH +: DATA_WIDTH];
          grant_d    = NUM_REQ'(1) << winner;
          last_d     = winner;
          busy_d     = 1'b1;
          byte_idx_d = 2'd0;
          sample_d   = 4'd0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (tick_end) begin
          bit_pos_d = 3'd0;
          shift_d   = cur_byte;
          tx_d      = cur_byte[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick_end) begin
          if (bit_pos_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_pos_d = bit_pos_q + 3'd1;
            tx_d      = shift_q[bit_pos_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick_end) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register update from the values
  // of the previous cycle, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // A reset abandons the word in flight, so the word latch is cleared too.
      state_q    <= IDLE;
      sample_q   <= '0;
      bit_pos_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      last_q     <= LAST_RESET;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      bit_pos_q  <= bit_pos_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a round-robin/framing reference model
// plus a behavioural UART receiver decoding the tx line into words.
module tb_uart_tx_arbiter;

  localparam int DW         = 32;
  localparam int NR         = 2;
  localparam int NB         = DW / 8;
  localparam int BYTE_TICKS = 160;
  localparam int WORD_TICKS = NB * BYTE_TICKS;

  logic clk = 1'b0;
  logic rstn;
  logic clken;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .clken (clken),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int period   = 1;
  int phase    = 0;
  bit ticked;
  int last_m   = NR - 1;

  logic [DW-1:0] rx_q[$];
  int            rx_err = 0;

  // One clock: returns at the falling edge with the outputs of the rising edge,
  // and ticked telling whether that edge consumed a clken tick.
  task automatic cyc();
    @(posedge clk);
    ticked = clken;
    @(negedge clk);
    phase = (phase + 1) % period;
    clken = (phase == 0);
  endtask

  task automatic set_period(input int p);
    period = p;
    phase  = 0;
    clken  = 1'b1;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Line level after t ticks of a word: 160-tick frames of start, 8 data, stop.
  function automatic logic exp_tx_at(input int t, input logic [DW-1:0] w);
    int b;
    int slot;
    if (t >= WORD_TICKS) return 1'b1;
    b    = t / BYTE_TICKS;
    slot = (t % BYTE_TICKS) / 16;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return w[b*8 + slot - 1];
  endfunction

  // Receiver sampling mid-bit on clken ticks, reassembling low byte first.
  initial begin : rx_model
    int            pos;
    bit            active;
    int            nbytes;
    logic [7:0]    byte_v;
    logic [DW-1:0] word_v;
    pos = 0; active = 1'b0; nbytes = 0; byte_v = '0; word_v = '0;
    forever begin
      @(posedge clk);
      if (rstn !== 1'b1) begin
        active = 1'b0;
        nbytes = 0;
      end else if (clken) begin
        if (!active) begin
          if (bus.tx === 1'b0) begin
            active = 1'b1;
            pos    = 1;
          end
        end else begin
          pos++;
          if (pos == 8) begin
            if (bus.tx !== 1'b0) rx_err++;
          end else if (pos >= 24 && pos <= 136 && pos % 16 == 8) begin
            byte_v[pos/16 - 1] = bus.tx;
          end else if (pos == 152) begin
            if (bus.tx !== 1'b1) rx_err++;
            word_v[nbytes*8 +: 8] = byte_v;
            nbytes++;
            active = 1'b0;
            if (nbytes == NB) begin
              rx_q.push_back(word_v);
              nbytes = 0;
            end
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rstn     = 1'b0;
    bus.req  = '0;
    cyc();
    cyc();
    rstn   = 1'b1;
    last_m = NR - 1;
    rx_q.delete();
  endtask

  // Requests one word and follows it to done (or to abort_t ticks).
  task automatic run_word(input string name, input logic [NR-1:0] req_now,
                          input logic [NR-1:0] req_after, input int exp_wait,
                          input bit scramble, input int abort_t, output int winner);
    int            exp_w, waited, t, cycles, tx_err, bad_t, err0, dbl_done, lo, hi;
    logic [DW-1:0] exp_word, got_word;
    logic [NR-1:0] exp_grant;
    logic          bad_tx;
    winner   = -1;
    exp_w    = rr_pick(req_now, last_m);
    exp_word = bus.data_in[exp_w*DW +: DW];
    exp_grant = '0;
    exp_grant[exp_w] = 1'b1;
    err0     = rx_err;
    bus.req  = req_now;
    waited   = 0;
    dbl_done = 0;
    do begin
      cyc();
      waited++;
      if (bus.done === 1'b1) dbl_done++;
    end while (bus.grant == '0 && waited < 64);

    checks++;
    if (bus.grant == '0) begin
      failures++;
      $display("FAIL %s grant_timeout: got grant=%b after %0d clk, required %b", name, bus.grant, waited, exp_grant);
      return;
    end
    checks++;
    if (bus.grant !== exp_grant) begin
      failures++;
      $display("FAIL %s grant: got %b required %b", name, bus.grant, exp_grant);
    end
    checks++;
    if (dbl_done !== 0) begin
      failures++;
      $display("FAIL %s done_pulse: got %0d extra done cycles, required 0", name, dbl_done);
    end
    if (exp_wait > 0) begin
      checks++;
      if (waited !== exp_wait) begin
        failures++;
        $display("FAIL %s grant_latency: got %0d clk required %0d", name, waited, exp_wait);
      end
    end
    for (int i = 0; i < NR; i++) if (bus.grant[i]) winner = i;
    last_m  = exp_w;
    bus.req = req_after;
    if (scramble) for (int i = 0; i < NR; i++) bus.data_in[i*DW +: DW] = $urandom();

    t = 0; cycles = 0; tx_err = 0; bad_t = -1; bad_tx = 1'bx;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      tx_err++;
      bad_t  = 0;
      bad_tx = bus.tx;
    end
    hi = WORD_TICKS * period;
    lo = hi - (period - 1);
    while (cycles < hi + 8) begin
      cyc();
      cycles++;
      if (ticked) t++;
      if (abort_t >= 0 && t >= abort_t) break;
      if (bus.done === 1'b1) break;
      if (bus.tx !== exp_tx_at(t, exp_word) || bus.busy !== 1'b1 || bus.grant !== '0) begin
        if (tx_err == 0) begin
          bad_t  = t;
          bad_tx = bus.tx;
        end
        tx_err++;
      end
    end
    checks++;
    if (tx_err != 0) begin
      failures++;
      $display("FAIL %s line: %0d bad cycles, first at tick %0d got tx=%b required tx=%b busy=1 grant=0",
               name, tx_err, bad_t, bad_tx, exp_tx_at(bad_t, exp_word));
    end
    if (abort_t >= 0) return;

    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout: got no done within %0d clk, required done after %0d ticks", name, cycles, WORD_TICKS);
      return;
    end
    checks++;
    if (t !== WORD_TICKS) begin
      failures++;
      $display("FAIL %s word_ticks: got %0d required %0d", name, t, WORD_TICKS);
    end
    checks++;
    if (cycles < lo || cycles > hi) begin
      failures++;
      $display("FAIL %s word_clks: got %0d required %0d..%0d", name, cycles, lo, hi);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL %s end_state: got busy=%b tx=%b required busy=0 tx=1", name, bus.busy, bus.tx);
    end
    got_word = 'x;
    if (rx_q.size() != 0) got_word = rx_q.pop_front();
    checks++;
    if (got_word !== exp_word || rx_err != err0) begin
      failures++;
      $display("FAIL %s rx_word: got %h (frame errors %0d) required %h", name, got_word, rx_err - err0, exp_word);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.grant !== '0) begin
      failures++;
      $display("FAIL reset_state: got tx=%b busy=%b done=%b grant=%b required 1 0 0 00",
               bus.tx, bus.busy, bus.done, bus.grant);
    end
  endtask

  task automatic test_single_word();
    int w;
    set_period(1);
    bus.data_in = '0;
    bus.data_in[0 +: DW] = 32'hA5C3_0F81;
    run_word("single", 2'b01, 2'b00, 0, 1'b0, -1, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL single_winner: got %0d required 0", w);
    end
  endtask

  task automatic test_simultaneous();
    int w0, w1, w2;
    apply_reset();
    bus.data_in = {32'h2222_2222, 32'h1111_1111};
    run_word("simul_a", 2'b11, 2'b11, 0, 1'b0, -1, w0);
    run_word("simul_b", 2'b11, 2'b00, 1, 1'b0, -1, w1);
    run_word("simul_c", 2'b11, 2'b00, 0, 1'b0, -1, w2);
    checks++;
    if (w0 !== 0 || w1 !== 1 || w2 !== 0) begin
      failures++;
      $display("FAIL simul_order: got %0d,%0d,%0d required 0,1,0", w0, w1, w2);
    end
  endtask

  task automatic test_round_robin();
    int w[4];
    bus.data_in = {$urandom(), $urandom()};
    run_word("rr_0", 2'b10, 2'b11, 0, 1'b1, -1, w[0]);
    run_word("rr_1", 2'b11, 2'b11, 1, 1'b1, -1, w[1]);
    run_word("rr_2", 2'b11, 2'b11, 1, 1'b1, -1, w[2]);
    run_word("rr_3", 2'b11, 2'b00, 1, 1'b1, -1, w[3]);
    checks++;
    if (w[0] !== 1 || w[1] !== 0 || w[2] !== 1 || w[3] !== 0) begin
      failures++;
      $display("FAIL rr_order: got %0d,%0d,%0d,%0d required 1,0,1,0", w[0], w[1], w[2], w[3]);
    end
  endtask

  task automatic test_sparse_clken();
    int w;
    set_period(3);
    bus.data_in = {$urandom(), $urandom()};
    run_word("sparse", 2'b01, 2'b00, 0, 1'b1, -1, w);
    set_period(1);
  endtask

  task automatic test_reset_mid_word();
    int w, bad, wa, wb;
    set_period(1);
    bus.data_in = {$urandom(), $urandom()};
    run_word("abort", 2'b01, 2'b01, 0, 1'b0, 2*BYTE_TICKS + 5*16 + 8, w);
    rstn    = 1'b0;
    bus.req = '0;
    cyc();
    rstn   = 1'b1;
    last_m = NR - 1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.grant !== '0) begin
      failures++;
      $display("FAIL abort_state: got tx=%b busy=%b done=%b grant=%b required 1 0 0 00",
               bus.tx, bus.busy, bus.done, bus.grant);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.done !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles and %0d words, required 0 and 0", bad, rx_q.size());
    end
    run_word("after_abort_both", 2'b11, 2'b00, 0, 1'b0, -1, wa);
    apply_reset();
    run_word("after_abort_one", 2'b10, 2'b00, 0, 1'b0, -1, wb);
    checks++;
    if (wa !== 0 || wb !== 1) begin
      failures++;
      $display("FAIL abort_rr: got %0d,%0d required 0,1", wa, wb);
    end
  endtask

  task automatic test_random();
    int            w;
    logic [NR-1:0] r;
    logic [NR-1:0] ra;
    for (int n = 0; n < 10; n++) begin
      set_period($urandom_range(1, 3));
      for (int i = 0; i < NR; i++) bus.data_in[i*DW +: DW] = $urandom();
      r  = NR'($urandom_range(1, (1 << NR) - 1));
      ra = NR'($urandom_range(0, (1 << NR) - 1));
      run_word("random", r, ra, 0, 1'b1, -1, w);
    end
    set_period(1);
  endtask

  initial begin
    rstn        = 1'b0;
    clken       = 1'b1;
    bus.req     = '0;
    bus.data_in = '0;
    test_reset();
    test_single_word();
    test_simultaneous();
    test_round_robin();
    test_sparse_clken();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
